// File: rtl/frame_sync_param_if.sv
// Serial bit stream in and frame-synchroniser status out, grouped for frame_sync_param.
interface frame_sync_param_if #(
  parameter int FRAME_LEN = 64,
  parameter int HEAD_LEN  = 8
);
  logic                            bit_en;
  logic                            data_in;
  logic                            is_frame_sychronized;
  logic [2:0]                      synchronizer_state;
  logic                            data_sync_out;
  logic                            data_sync_valid;
  logic                            frame_start;
  logic [$clog2(FRAME_LEN)-1:0]    bit_pos;
  logic [$clog2(HEAD_LEN+1)-1:0]   head_err;
  logic [7:0]                      lock_loss_cnt;

  modport master (
    output bit_en, data_in,
    input  is_frame_sychronized, synchronizer_state, data_sync_out, data_sync_valid,
           frame_start, bit_pos, head_err, lock_loss_cnt
  );

  modport slave (
    input  bit_en, data_in,
    output is_frame_sychronized, synchronizer_state, data_sync_out, data_sync_valid,
           frame_start, bit_pos, head_err, lock_loss_cnt
  );
endinterface

// File: rtl/frame_sync_param.sv
// Serial frame synchroniser: hunts for a header with bounded bit errors, confirms lock
// over several frames and flywheels through a limited number of missed headers.
module frame_sync_param #(
  parameter int                  FRAME_LEN    = 64,
  parameter int                  HEAD_LEN     = 8,
  parameter logic [HEAD_LEN-1:0] HEAD_PATTERN = 8'b01111110,
  parameter int                  MAX_ERR      = 0,
  parameter int                  CONFIRM_N    = 2,
  parameter int                  LOSS_N       = 2
) (
  input logic               clk_out,
  input logic               rst_n,
  frame_sync_param_if.slave bus
);
  localparam int POS_W  = $clog2(FRAME_LEN);
  localparam int ERR_W  = $clog2(HEAD_LEN+1);
  localparam int HIT_W  = $clog2(CONFIRM_N+1);
  localparam int MISS_W = $clog2(LOSS_N+1);

  typedef enum logic [2:0] {
    HUNT     = 3'b000,
    FLYWHEEL = 3'b001,
    SYNC     = 3'b010,
    VERIFY   = 3'b011
  } state_t;

  state_t              state;
  logic [HEAD_LEN-1:0] head_buf;
  logic [POS_W-1:0]    bit_pos;
  logic [HIT_W-1:0]    hit_cnt;
  logic [MISS_W-1:0]   miss_cnt;
  logic [ERR_W-1:0]    head_err;
  logic [7:0]          lock_loss_cnt;
  logic                is_sync;
  logic                data_sync_out;
  logic                data_sync_valid;
  logic                frame_start;

  logic [HEAD_LEN-1:0] nxt;
  logic [ERR_W-1:0]    err;
  logic                match;
  logic                boundary;

  // Header window as it will look once the current bit is shifted in.
  always_comb begin
    nxt = {head_buf[HEAD_LEN-2:0], bus.data_in};
    err = '0;
    for (int i = 0; i < HEAD_LEN; i++) begin
      err = err + ERR_W'(nxt[i] ^ HEAD_PATTERN[i]);
    end
    match    = (err <= ERR_W'(MAX_ERR));
    boundary = (bit_pos == POS_W'(FRAME_LEN-1));
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state           <= HUNT;
      head_buf        <= '0;
      bit_pos         <= '0;
      hit_cnt         <= '0;
      miss_cnt        <= '0;
      head_err        <= '0;
      lock_loss_cnt   <= '0;
      is_sync         <= 1'b0;
      data_sync_out   <= 1'b0;
      data_sync_valid <= 1'b0;
      frame_start     <= 1'b0;
    end else if (!bus.bit_en) begin
      data_sync_valid <= 1'b0;
      frame_start     <= 1'b0;
    end else begin
      head_buf        <= nxt;
      data_sync_out   <= head_buf[HEAD_LEN-1];
      data_sync_valid <= 1'b1;
      frame_start     <= 1'b0;
      case (state)
        HUNT: begin
          bit_pos <= '0;
          hit_cnt <= '0;
          if (match) begin
            state    <= VERIFY;
            hit_cnt  <= HIT_W'(1);
            head_err <= err;
          end
        end
        VERIFY: begin
          if (boundary) begin
            bit_pos  <= '0;
            head_err <= err;
            if (match) begin
              hit_cnt <= hit_cnt + HIT_W'(1);
              if (hit_cnt == HIT_W'(CONFIRM_N-1)) begin
                state       <= SYNC;
                is_sync     <= 1'b1;
                frame_start <= 1'b1;
              end
            end else begin
              state   <= HUNT;
              hit_cnt <= '0;
            end
          end else begin
            bit_pos <= bit_pos + POS_W'(1);
          end
        end
        SYNC: begin
          if (boundary) begin
            bit_pos     <= '0;
            head_err    <= err;
            frame_start <= 1'b1;
            if (!match) begin
              state    <= FLYWHEEL;
              miss_cnt <= MISS_W'(1);
            end
          end else begin
            bit_pos <= bit_pos + POS_W'(1);
          end
        end
        FLYWHEEL: begin
          // Keep the predicted frame timing until LOSS_N headers in a row are missed.
          if (boundary) begin
            bit_pos  <= '0;
            head_err <= err;
            if (match) begin
              state       <= SYNC;
              miss_cnt    <= '0;
              frame_start <= 1'b1;
            end else if (miss_cnt == MISS_W'(LOSS_N-1)) begin
              state    <= HUNT;
              miss_cnt <= '0;
              hit_cnt  <= '0;
              is_sync  <= 1'b0;
              if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end else begin
              miss_cnt    <= miss_cnt + MISS_W'(1);
              frame_start <= 1'b1;
            end
          end else begin
            bit_pos <= bit_pos + POS_W'(1);
          end
        end
        default: begin
          state    <= HUNT;
          bit_pos  <= '0;
          hit_cnt  <= '0;
          miss_cnt <= '0;
          is_sync  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.is_frame_sychronized = is_sync;
  assign bus.synchronizer_state   = state;
  assign bus.data_sync_out        = data_sync_out;
  assign bus.data_sync_valid      = data_sync_valid;
  assign bus.frame_start          = frame_start;
  assign bus.bit_pos              = bit_pos;
  assign bus.head_err             = head_err;
  assign bus.lock_loss_cnt        = lock_loss_cnt;
endmodule

// File: tb/tb_frame_sync_param.sv
// Drives two synchronisers (MAX_ERR 0 and 1) with one bit stream and compares both
// against a bit-history reference model plus directed expectations.
module tb_frame_sync_param;
  localparam int FRAME_LEN = 64;
  localparam int HEAD_LEN  = 8;
  localparam int CONFIRM_N = 2;
  localparam int LOSS_N    = 2;
  localparam logic [7:0] PAT = 8'h7E;
  localparam int MODE_HUNT = 0, MODE_VERIFY = 1, MODE_SYNC = 2, MODE_FLY = 3;

  logic clk_out = 1'b0;
  logic rst_n;
  logic bit_en;
  logic data_in;
  bit   gated;
  int   checks;
  int   errors;

  always #5 clk_out = ~clk_out;

  frame_sync_param_if #(.FRAME_LEN(FRAME_LEN), .HEAD_LEN(HEAD_LEN)) bus0 ();
  frame_sync_param_if #(.FRAME_LEN(FRAME_LEN), .HEAD_LEN(HEAD_LEN)) bus1 ();

  assign bus0.bit_en  = bit_en;
  assign bus0.data_in = data_in;
  assign bus1.bit_en  = bit_en;
  assign bus1.data_in = data_in;

  frame_sync_param #(.FRAME_LEN(FRAME_LEN), .HEAD_LEN(HEAD_LEN), .HEAD_PATTERN(PAT),
                     .MAX_ERR(0), .CONFIRM_N(CONFIRM_N), .LOSS_N(LOSS_N))
    dut0 (.clk_out(clk_out), .rst_n(rst_n), .bus(bus0));

  frame_sync_param #(.FRAME_LEN(FRAME_LEN), .HEAD_LEN(HEAD_LEN), .HEAD_PATTERN(PAT),
                     .MAX_ERR(1), .CONFIRM_N(CONFIRM_N), .LOSS_N(LOSS_N))
    dut1 (.clk_out(clk_out), .rst_n(rst_n), .bus(bus1));

  // Reference model: per-instance lock mode, anchored on the enabled-bit index of the
  // header that started the current lock attempt.
  bit   hist[$];
  int   m_mode[2], m_anchor[2], m_hits[2], m_miss[2], m_herr[2], m_loss[2], m_pos[2];
  logic m_fs[2], m_valid[2], m_dout[2];

  function automatic int mode_code(input int m);
    case (m)
      MODE_VERIFY: return 3;
      MODE_SYNC:   return 2;
      MODE_FLY:    return 1;
      default:     return 0;
    endcase
  endfunction

  function automatic int window_errors(input int n);
    int e = 0;
    for (int k = 0; k < HEAD_LEN; k++) begin
      bit b = (n - k >= 0) ? hist[n-k] : 1'b0;
      if (b != PAT[k]) e++;
    end
    return e;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = MODE_HUNT; m_anchor[i] = 0; m_hits[i] = 0; m_miss[i] = 0;
      m_herr[i] = 0; m_loss[i] = 0; m_pos[i] = 0;
      m_fs[i] = 1'b0; m_valid[i] = 1'b0; m_dout[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic en, input logic d);
    int n, e;
    bit match, bnd;
    if (!en) begin
      for (int i = 0; i < 2; i++) begin
        m_fs[i] = 1'b0; m_valid[i] = 1'b0;
      end
    end else begin
      hist.push_back(d);
      n = hist.size() - 1;
      e = window_errors(n);
      for (int i = 0; i < 2; i++) begin
        match      = (e <= i);
        m_fs[i]    = 1'b0;
        m_valid[i] = 1'b1;
        m_dout[i]  = (n >= HEAD_LEN) ? hist[n-HEAD_LEN] : 1'b0;
        if (m_mode[i] == MODE_HUNT) begin
          if (match) begin
            m_mode[i] = MODE_VERIFY; m_anchor[i] = n; m_hits[i] = 1; m_herr[i] = e;
          end
        end else begin
          bnd = ((n - m_anchor[i]) % FRAME_LEN == 0);
          if (bnd) begin
            m_herr[i] = e;
            if (m_mode[i] == MODE_VERIFY) begin
              if (match) begin
                m_hits[i]++;
                if (m_hits[i] == CONFIRM_N) m_mode[i] = MODE_SYNC;
              end else begin
                m_mode[i] = MODE_HUNT; m_hits[i] = 0;
              end
            end else if (m_mode[i] == MODE_SYNC) begin
              if (!match) begin
                m_mode[i] = MODE_FLY; m_miss[i] = 1;
              end
            end else begin
              if (match) begin
                m_mode[i] = MODE_SYNC; m_miss[i] = 0;
              end else begin
                m_miss[i]++;
                if (m_miss[i] == LOSS_N) begin
                  m_mode[i] = MODE_HUNT; m_miss[i] = 0;
                  if (m_loss[i] < 255) m_loss[i]++;
                end
              end
            end
            m_fs[i] = (m_mode[i] == MODE_SYNC) || (m_mode[i] == MODE_FLY);
          end
        end
        m_pos[i] = (m_mode[i] == MODE_HUNT) ? 0 : (n - m_anchor[i]) % FRAME_LEN;
      end
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic [2:0] st, input logic sync,
                            input logic dout, input logic valid, input logic fs,
                            input logic [5:0] pos, input logic [3:0] herr, input logic [7:0] loss);
    check_output($sformatf("dut%0d state", i), 32'(st), 32'(mode_code(m_mode[i])));
    check_output($sformatf("dut%0d sync", i), 32'(sync),
                 32'((m_mode[i] == MODE_SYNC) || (m_mode[i] == MODE_FLY)));
    check_output($sformatf("dut%0d dout", i), 32'(dout), 32'(m_dout[i]));
    check_output($sformatf("dut%0d valid", i), 32'(valid), 32'(m_valid[i]));
    check_output($sformatf("dut%0d frame_start", i), 32'(fs), 32'(m_fs[i]));
    check_output($sformatf("dut%0d bit_pos", i), 32'(pos), 32'(m_pos[i]));
    check_output($sformatf("dut%0d head_err", i), 32'(herr), 32'(m_herr[i]));
    check_output($sformatf("dut%0d lock_loss", i), 32'(loss), 32'(m_loss[i]));
  endtask

  task automatic check_all();
    check_inst(0, bus0.synchronizer_state, bus0.is_frame_sychronized, bus0.data_sync_out,
               bus0.data_sync_valid, bus0.frame_start, bus0.bit_pos, bus0.head_err,
               bus0.lock_loss_cnt);
    check_inst(1, bus1.synchronizer_state, bus1.is_frame_sychronized, bus1.data_sync_out,
               bus1.data_sync_valid, bus1.frame_start, bus1.bit_pos, bus1.head_err,
               bus1.lock_loss_cnt);
  endtask

  task automatic apply_stimulus(input logic en, input logic d);
    bit_en  = en;
    data_in = d;
    @(posedge clk_out);
    #1;
    model_step(en, d);
    check_all();
  endtask

  task automatic send_bit(input logic d);
    int gaps = 0;
    if (gated) begin
      while (($urandom_range(0, 1) == 1) && (gaps < 8)) begin
        apply_stimulus(1'b0, 1'($urandom_range(0, 1)));
        gaps++;
      end
    end
    apply_stimulus(1'b1, d);
  endtask

  task automatic send_header(input logic [7:0] h);
    for (int k = 7; k >= 0; k--) send_bit(h[k]);
  endtask

  // Random filler with every third bit forced low, so it can never hold six ones in a row.
  task automatic send_payload(input int len);
    for (int k = 0; k < len; k++) send_bit((k % 3 == 2) ? 1'b0 : 1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input logic [7:0] h);
    send_header(h);
    send_payload(FRAME_LEN - HEAD_LEN);
  endtask

  task automatic do_reset();
    bit_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk_out);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    gated   = 1'b0;
    bit_en  = 1'b0;
    data_in = 1'b0;
    rst_n   = 1'b1;
    model_reset();
    #1;
    rst_n = 1'b0;
    @(posedge clk_out);
    #1;
    check_all();
    rst_n = 1'b1;

    $display("[TB] acquire");
    send_payload($urandom_range(10, 40));
    send_header(PAT);
    check_output("acq verify state", 32'(bus0.synchronizer_state), 32'd3);
    check_output("acq verify pos", 32'(bus0.bit_pos), 32'd0);
    send_payload(FRAME_LEN - HEAD_LEN);
    send_header(PAT);
    check_output("acq sync state", 32'(bus0.synchronizer_state), 32'd2);
    check_output("acq sync flag", 32'(bus0.is_frame_sychronized), 32'd1);
    check_output("acq frame_start", 32'(bus0.frame_start), 32'd1);
    send_payload(FRAME_LEN - HEAD_LEN);
    send_header(PAT);
    check_output("acq frame_start 3", 32'(bus0.frame_start), 32'd1);
    check_output("acq pos 3", 32'(bus0.bit_pos), 32'd0);

    $display("[TB] false lock");
    do_reset();
    send_payload($urandom_range(10, 40));
    send_frame(PAT);
    send_header(8'h00);
    check_output("false lock state", 32'(bus0.synchronizer_state), 32'd0);
    check_output("false lock loss", 32'(bus0.lock_loss_cnt), 32'd0);

    $display("[TB] flywheel and loss");
    do_reset();
    send_payload($urandom_range(10, 40));
    send_frame(PAT);
    send_frame(PAT);
    send_header(8'h7F);
    check_output("fly state", 32'(bus0.synchronizer_state), 32'd1);
    check_output("fly sync", 32'(bus0.is_frame_sychronized), 32'd1);
    check_output("fly frame_start", 32'(bus0.frame_start), 32'd1);
    check_output("fly head_err", 32'(bus0.head_err), 32'd1);
    send_payload(FRAME_LEN - HEAD_LEN);
    send_header(PAT);
    check_output("fly back state", 32'(bus0.synchronizer_state), 32'd2);
    send_payload(FRAME_LEN - HEAD_LEN);
    send_frame(8'h7F);
    send_header(8'h7F);
    check_output("loss state", 32'(bus0.synchronizer_state), 32'd0);
    check_output("loss count", 32'(bus0.lock_loss_cnt), 32'd1);
    check_output("loss sync", 32'(bus0.is_frame_sychronized), 32'd0);
    send_bit(1'b0);

    $display("[TB] error tolerance");
    do_reset();
    for (int k = 0; k < 16; k++) send_bit(1'b0);
    send_frame(PAT);
    send_header(PAT);
    check_output("tol sync state", 32'(bus1.synchronizer_state), 32'd2);
    for (int r = 0; r < 2; r++) begin
      send_payload(FRAME_LEN - HEAD_LEN);
      send_header(8'h7C);
      check_output("tol err1 state", 32'(bus1.synchronizer_state), 32'd2);
      check_output("tol err1", 32'(bus1.head_err), 32'd1);
      send_payload(FRAME_LEN - HEAD_LEN);
      send_header(PAT);
      check_output("tol err0", 32'(bus1.head_err), 32'd0);
    end
    send_payload(FRAME_LEN - HEAD_LEN);
    send_header(8'h3C);
    check_output("tol fly state", 32'(bus1.synchronizer_state), 32'd1);
    check_output("tol err2", 32'(bus1.head_err), 32'd2);

    $display("[TB] gated enable and async reset");
    do_reset();
    gated = 1'b1;
    send_payload($urandom_range(10, 40));
    send_header(PAT);
    check_output("gate verify state", 32'(bus0.synchronizer_state), 32'd3);
    send_payload(FRAME_LEN - HEAD_LEN);
    send_header(PAT);
    check_output("gate sync state", 32'(bus0.synchronizer_state), 32'd2);
    send_frame(PAT);
    send_payload(20);
    gated = 1'b0;
    do_reset();
    check_output("rst state", 32'(bus0.synchronizer_state), 32'd0);
    check_output("rst pos", 32'(bus0.bit_pos), 32'd0);
    check_output("rst sync", 32'(bus0.is_frame_sychronized), 32'd0);
    send_payload($urandom_range(10, 40));
    send_frame(PAT);
    send_header(PAT);
    check_output("reacq state", 32'(bus0.synchronizer_state), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
